mapper_ctx_ctrl: RTL and testbench

Context save/restore sequencer and write arbiter for the 4510 user mapper's hypervisor register port. On hypervisor entry it snapshots the four user mapper bytes (offset/enable for both halves) into a shadow file; on hypervisor exit it writes them back. Between sequences it arbitrates hypervisor CPU I/O writes onto the same single mapper write port, never while a MAP instruction is in flight.

---
 rtl/mapper_ctx_ctrl.sv | 110 +++++++++++
 tb/tb_mapper_ctx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_ctx_ctrl.sv
// Hypervisor context save/restore sequencer for the user mapper bytes, plus
// arbitration of hypervisor CPU writes onto the single mapper write port.
module mapper_ctx_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready,
    input  logic       map_busy,
    input  logic       save_req,
    input  logic       restore_req,
    input  logic       cpu_wr,
    input  logic [1:0] cpu_wr_sel,
    input  logic [7:0] cpu_wr_data,
    input  logic [7:0] map_reg_data,
    output logic [1:0] rd_sel,
    output logic       rd_override,
    output logic       hyp_load_user_reg,
    output logic [1:0] map_reg_write_sel,
    output logic [7:0] wr_data,
    output logic       cpu_wr_ack,
    input  logic [1:0] shadow_sel,
    output logic [7:0] shadow_data,
    output logic       busy,
    output logic       done
);
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 2;
    localparam int unsigned NB = 4;

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [DW-1:0]   shadow [NB];
    logic            pend_save;
    logic            pend_restore;

    logic start_save, start_restore;
    logic in_idle, in_save, in_restore;
    logic restore_wr, cpu_go;

    // Incoming pulses count as pending so a request is acted on the cycle it arrives.
    assign start_save    = pend_save | save_req;
    assign start_restore = pend_restore | restore_req;
    assign in_idle       = (state == IDLE);
    assign in_save       = (state == SAVE);
    assign in_restore    = (state == RESTORE);

    assign restore_wr = in_restore & ready & ~map_busy;
    // reset_n gating keeps the combinational strobe quiet while reset is held.
    assign cpu_go     = reset_n & in_idle & ~start_save & ~start_restore
                      & cpu_wr & ready & ~map_busy;

    assign cpu_wr_ack        = cpu_go;
    assign hyp_load_user_reg = restore_wr | cpu_go;
    assign map_reg_write_sel = in_restore ? cnt : (cpu_go ? cpu_wr_sel : SW'(0));
    assign wr_data           = in_restore ? shadow[cnt] : (cpu_go ? cpu_wr_data : DW'(0));
    assign rd_override       = in_save;
    assign rd_sel            = in_save ? cnt : SW'(0);
    assign busy              = ~in_idle;
    assign shadow_data       = shadow[shadow_sel];

    // Sequencer state, byte counter, pending requests and shadow file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pend_save    <= 1'b0;
            pend_restore <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < NB; i++) shadow[i] <= '0;
        end else begin
            done         <= 1'b0;
            pend_save    <= start_save;
            pend_restore <= start_restore;
            case (state)
                IDLE: begin
                    if (start_save) begin
                        state     <= SAVE;
                        cnt       <= '0;
                        pend_save <= 1'b0;
                    end else if (start_restore) begin
                        state        <= RESTORE;
                        cnt          <= '0;
                        pend_restore <= 1'b0;
                    end
                end
                SAVE: begin
                    if (ready) begin
                        shadow[cnt] <= map_reg_data;
                        cnt         <= cnt + SW'(1);
                        if (cnt == SW'(NB - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                RESTORE: begin
                    if (restore_wr) begin
                        cnt <= cnt + SW'(1);
                        if (cnt == SW'(NB - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mapper_ctx_ctrl.sv
// Directed bench for mapper_ctx_ctrl with a small behavioural mapper model.
module tb_mapper_ctx_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ready = 1'b1;
    logic       map_busy = 1'b0;
    logic       save_req = 1'b0;
    logic       restore_req = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [1:0] cpu_wr_sel = 2'd0;
    logic [7:0] cpu_wr_data = 8'd0;
    logic [7:0] map_reg_data;
    logic [1:0] rd_sel;
    logic       rd_override;
    logic       hyp_load_user_reg;
    logic [1:0] map_reg_write_sel;
    logic [7:0] wr_data;
    logic       cpu_wr_ack;
    logic [1:0] shadow_sel = 2'd0;
    logic [7:0] shadow_data;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [7:0] map_mem [4];
    logic [1:0] wlog_sel [$];
    logic [7:0] wlog_data [$];
    int         bad_strobe = 0;

    mapper_ctx_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .map_busy(map_busy),
        .save_req(save_req), .restore_req(restore_req), .cpu_wr(cpu_wr),
        .cpu_wr_sel(cpu_wr_sel), .cpu_wr_data(cpu_wr_data),
        .map_reg_data(map_reg_data), .rd_sel(rd_sel), .rd_override(rd_override),
        .hyp_load_user_reg(hyp_load_user_reg), .map_reg_write_sel(map_reg_write_sel),
        .wr_data(wr_data), .cpu_wr_ack(cpu_wr_ack), .shadow_sel(shadow_sel),
        .shadow_data(shadow_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign map_reg_data = map_mem[rd_sel];

    // Mapper model: sample the write strobe late in each cycle, ahead of the edge.
    always begin
        @(negedge clk);
        #4;
        if (hyp_load_user_reg) begin
            map_mem[map_reg_write_sel] = wr_data;
            wlog_sel.push_back(map_reg_write_sel);
            wlog_data.push_back(wr_data);
            if (map_busy) bad_strobe++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_map(input logic [7:0] b0, b1, b2, b3);
        map_mem[0] = b0; map_mem[1] = b1; map_mem[2] = b2; map_mem[3] = b3;
    endtask

    task automatic chk_shadow(input string nm, input logic [7:0] b0, b1, b2, b3);
        logic [7:0] e [4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        for (int i = 0; i < 4; i++) begin
            shadow_sel = 2'(i);
            #1;
            chk($sformatf("%s shadow[%0d]", nm, i), 32'(shadow_data), 32'(e[i]));
        end
    endtask

    task automatic clear_log();
        wlog_sel.delete();
        wlog_data.delete();
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] sel;
        logic [7:0] data;
        logic       rdy;
        logic       mb;
        logic       e_ack;
        logic [1:0] e_sel;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_map(8'h00, 8'h00, 8'h00, 8'h00);
        vecs[0] = '{1'b1, 2'd2, 8'h3C, 1'b1, 1'b0, 1'b1, 2'd2, 8'h3C};
        vecs[1] = '{1'b1, 2'd2, 8'h3C, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[2] = '{1'b1, 2'd1, 8'h77, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[3] = '{1'b0, 2'd3, 8'hFF, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[4] = '{1'b1, 2'd3, 8'hFF, 1'b1, 1'b0, 1'b1, 2'd3, 8'hFF};
        vecs[5] = '{1'b1, 2'd0, 8'h81, 1'b1, 1'b0, 1'b1, 2'd0, 8'h81};

        // Reset state
        #2;
        cpu_wr = 1'b1; #1;
        chk("rst ack", 32'(cpu_wr_ack), 0);
        chk("rst strobe", 32'(hyp_load_user_reg), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst rd_override", 32'(rd_override), 0);
        chk_shadow("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        cpu_wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // IDLE arbitration table
        for (int i = 0; i < 6; i++) begin
            cpu_wr = vecs[i].wr; cpu_wr_sel = vecs[i].sel; cpu_wr_data = vecs[i].data;
            ready = vecs[i].rdy; map_busy = vecs[i].mb;
            #1;
            chk($sformatf("vec%0d ack", i), 32'(cpu_wr_ack), 32'(vecs[i].e_ack));
            chk($sformatf("vec%0d strobe", i), 32'(hyp_load_user_reg), 32'(vecs[i].e_ack));
            chk($sformatf("vec%0d sel", i), 32'(map_reg_write_sel), 32'(vecs[i].e_sel));
            chk($sformatf("vec%0d data", i), 32'(wr_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d busy", i), 32'(busy), 0);
            @(negedge clk);
        end
        cpu_wr = 1'b0; ready = 1'b1; map_busy = 1'b0;
        @(negedge clk);

        // Save with ready high
        set_map(8'h12, 8'h34, 8'h56, 8'h78);
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("save c%0d busy", i), 32'(busy), 1);
            chk($sformatf("save c%0d rd_override", i), 32'(rd_override), 1);
            chk($sformatf("save c%0d rd_sel", i), 32'(rd_sel), 32'(i));
            chk($sformatf("save c%0d done", i), 32'(done), 0);
            @(negedge clk);
        end
        #1;
        chk("save done", 32'(done), 1);
        chk("save busy end", 32'(busy), 0);
        chk("save rd_sel end", 32'(rd_sel), 0);
        @(negedge clk);
        #1;
        chk("save done pulse", 32'(done), 0);
        chk_shadow("save", 8'h12, 8'h34, 8'h56, 8'h78);

        // Restore with map_busy stall on cycles 2-3
        begin
            logic       mb [6];
            logic       es [6];
            logic [1:0] esel [6];
            logic [7:0] sh [4];
            mb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            es = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            esel = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
            sh = '{8'h12, 8'h34, 8'h56, 8'h78};
            @(negedge clk);
            set_map(8'h00, 8'h00, 8'h00, 8'h00);
            clear_log();
            restore_req = 1'b1;
            @(negedge clk);
            restore_req = 1'b0;
            for (int k = 0; k < 6; k++) begin
                map_busy = mb[k];
                #1;
                chk($sformatf("rst c%0d strobe", k), 32'(hyp_load_user_reg), 32'(es[k]));
                chk($sformatf("rst c%0d sel", k), 32'(map_reg_write_sel), 32'(esel[k]));
                chk($sformatf("rst c%0d data", k), 32'(wr_data), 32'(sh[esel[k]]));
                chk($sformatf("rst c%0d busy", k), 32'(busy), 1);
                @(negedge clk);
            end
            map_busy = 1'b0;
            #1;
            chk("restore done", 32'(done), 1);
            chk("restore busy end", 32'(busy), 0);
            chk("restore writes", 32'(wlog_sel.size()), 4);
            chk("restore stalled strobes", 32'(bad_strobe), 0);
            for (int i = 0; i < 4; i++)
                chk($sformatf("restore map[%0d]", i), 32'(map_mem[i]), 32'(sh[i]));
        end

        // Save with ready toggling
        begin
            logic [1:0] erd [7];
            erd = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
            @(negedge clk);
            set_map(8'h9A, 8'hBC, 8'hDE, 8'hF0);
            save_req = 1'b1;
            @(negedge clk);
            save_req = 1'b0;
            for (int k = 0; k < 7; k++) begin
                ready = (k % 2 == 0);
                #1;
                chk($sformatf("gap c%0d rd_sel", k), 32'(rd_sel), 32'(erd[k]));
                chk($sformatf("gap c%0d busy", k), 32'(busy), 1);
                @(negedge clk);
            end
            ready = 1'b1;
            #1;
            chk("gap done", 32'(done), 1);
            chk_shadow("gap", 8'h9A, 8'hBC, 8'hDE, 8'hF0);
        end

        // cpu_wr held across a save request
        @(negedge clk);
        set_map(8'h11, 8'h22, 8'h33, 8'h44);
        clear_log();
        cpu_wr = 1'b1; cpu_wr_sel = 2'd1; cpu_wr_data = 8'hA5; save_req = 1'b1;
        #1;
        chk("arb req ack", 32'(cpu_wr_ack), 0);
        chk("arb req strobe", 32'(hyp_load_user_reg), 0);
        @(negedge clk);
        save_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("arb c%0d ack", i), 32'(cpu_wr_ack), 0);
            chk($sformatf("arb c%0d strobe", i), 32'(hyp_load_user_reg), 0);
            @(negedge clk);
        end
        #1;
        chk("arb done", 32'(done), 1);
        chk("arb ack", 32'(cpu_wr_ack), 1);
        chk("arb sel", 32'(map_reg_write_sel), 1);
        chk("arb data", 32'(wr_data), 32'h00A5);
        @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("arb writes", 32'(wlog_sel.size()), 1);
        if (wlog_sel.size() == 1) begin
            chk("arb log sel", 32'(wlog_sel[0]), 1);
            chk("arb log data", 32'(wlog_data[0]), 32'h00A5);
        end
        chk_shadow("arb", 8'h11, 8'h22, 8'h33, 8'h44);

        // Simultaneous save and restore
        begin
            int   dones;
            logic bz [14];
            dones = 0;
            @(negedge clk);
            set_map(8'h01, 8'h02, 8'h03, 8'h04);
            clear_log();
            save_req = 1'b1; restore_req = 1'b1;
            @(negedge clk);
            save_req = 1'b0; restore_req = 1'b0;
            for (int k = 0; k < 14; k++) begin
                #1;
                if (done) dones++;
                bz[k] = busy;
                @(negedge clk);
            end
            chk("both dones", 32'(dones), 2);
            chk("both gap busy", 32'(bz[4]), 0);
            chk("both restore busy", 32'(bz[5]), 1);
            chk("both writes", 32'(wlog_sel.size()), 4);
            if (wlog_sel.size() == 4)
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("both log sel%0d", i), 32'(wlog_sel[i]), 32'(i));
                    chk($sformatf("both log data%0d", i), 32'(wlog_data[i]), 32'(i + 1));
                end
        end

        // Reset asserted mid-restore at cnt=2
        clear_log();
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst sel before", 32'(map_reg_write_sel), 2);
        cpu_wr = 1'b1; cpu_wr_sel = 2'd3; cpu_wr_data = 8'h5A;
        reset_n = 1'b0;
        #1;
        chk("midrst strobe", 32'(hyp_load_user_reg), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst sel", 32'(map_reg_write_sel), 0);
        chk("midrst data", 32'(wr_data), 0);
        chk("midrst ack", 32'(cpu_wr_ack), 0);
        chk("midrst done", 32'(done), 0);
        chk_shadow("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        cpu_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst writes", 32'(wlog_sel.size()), 2);
        chk("midrst busy after", 32'(busy), 0);
        chk("midrst map[2] kept", 32'(map_mem[2]), 32'h0003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
